// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 codes and store byte-mask helper for the load/store unit.
package lsu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Store byte mask before lane shift; every undefined encoding behaves as a word.
    function automatic logic [3:0] base_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B:    base_mask = 4'b0001;
            F3_H:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift/mask, load extract/extend, misalignment detect.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        wen_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [7:0]  wmask_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  mask_shift;
    logic [31:0] lane;
    logic        is_b;
    logic        is_h;

    always_comb begin
        // Lanes shifted past byte 3 fall off the word.
        mask_shift = {4'b0000, base_mask(funct3_i)} << off_i;
        wmask_o    = {4'b0000, mask_shift[3:0]};
        wdata_o    = wdata_i << {off_i, 3'b000};
        lane       = rdata_i >> {off_i, 3'b000};

        case (funct3_i)
            F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   rdata_o = {24'd0, lane[7:0]};
            F3_HU:   rdata_o = {16'd0, lane[15:0]};
            default: rdata_o = lane;
        endcase

        // The unsigned encodings only exist for loads.
        is_b       = (funct3_i == F3_B) || (!wen_i && (funct3_i == F3_BU));
        is_h       = (funct3_i == F3_H) || (!wen_i && (funct3_i == F3_HU));
        misalign_o = is_h ? off_i[0] : (!is_b && (off_i != 2'b00));
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM, latency counter and request/response registers.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests answered with resp_err=1).
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wmask,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        in_wait;
    logic        sel_wen;
    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic [31:0] sel_wdata;
    logic [7:0]  al_wmask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misalign;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign in_wait    = (state_q == ST_WAIT);
    assign accept     = req_valid && req_ready;

    // In IDLE the aligner looks at the live request so misalignment is known at accept.
    always_comb begin
        sel_wen   = req_ready ? req_wen        : wen_q;
        sel_f3    = req_ready ? req_funct3     : f3_q;
        sel_off   = req_ready ? req_addr[1:0]  : addr_q[1:0];
        sel_wdata = req_ready ? req_wdata      : wdata_q;
    end

    lsu_align u_align (
        .wen_i      (sel_wen),
        .funct3_i   (sel_f3),
        .off_i      (sel_off),
        .wdata_i    (sel_wdata),
        .rdata_i    (mem_rdata),
        .wmask_o    (al_wmask),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;
`else
    logic unused_misalign;
    assign unused_misalign = al_misalign;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wen_d   = req_wen;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d   = al_misalign;
                    if (al_misalign) begin
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = wen_q ? 32'd0 : al_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // The counter only counts down, so its load value marks the first WAIT cycle.
    assign mem_addr   = in_wait ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wmask  = (in_wait && wen_q) ? al_wmask : 8'd0;
    assign mem_wdata  = (in_wait && wen_q) ? al_wdata : 32'd0;
    assign mem_wen    = in_wait && wen_q && (cnt_q == CNT_INIT);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_err   = resp_valid && err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
